// File: rtl/servo_seq_pkg.sv
// Shared definitions for the servo ramp sequencer: channel count, FSM states
// and the round-robin channel arithmetic used by the arbiter.
package servo_seq_pkg;

    localparam int CH_COUNT         = 3;
    localparam int CH_W             = 2;
    localparam int CTRL_MAX_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        STEP = 2'd2
    } seq_state_t;

    // base + offs modulo CH_COUNT; both operands stay small enough that one
    // subtraction is sufficient.
    function automatic logic [CH_W-1:0] chan_wrap(input logic [CH_W-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= CH_COUNT) begin
            sum = sum - CH_COUNT;
        end
        return CH_W'(sum);
    endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Free-running step-slot timer: tick is high for one cycle every STEP_TICKS
// cycles, when the counter sits at its last value.
module servo_tick_gen #(
    parameter int STEP_TICKS = 5000000
) (
    input  logic clk_in,
    input  logic rst_in,
    output logic tick
);

    localparam int               CNT_W = $clog2(STEP_TICKS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(STEP_TICKS - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/servo_ramp_sequencer.sv
// Slew-limited position scheduler for three servo channels: one shared step
// slot per tick, granted round-robin among channels that are still moving.
module servo_ramp_sequencer
    import servo_seq_pkg::*;
#(
    parameter int STEP_TICKS = 5000000,
    parameter int CTRL_MAX   = CTRL_MAX_DEFAULT
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                cmd_valid,
    input  logic [1:0]          cmd_chan,
    input  logic [7:0]          cmd_pos,
    output logic                cmd_ready,
    output logic                cmd_err,
    output logic [7:0]          pwm_ctrl0,
    output logic [7:0]          pwm_ctrl1,
    output logic [7:0]          pwm_ctrl2,
    output logic [CH_COUNT-1:0] busy,
    output logic [CH_COUNT-1:0] done
);

    localparam logic [7:0] POS_MAX = 8'(CTRL_MAX);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [7:0]       pos    [CH_COUNT];
    logic [7:0]       target [CH_COUNT];
    logic [CH_W-1:0]  rr_ptr;
    logic [CH_W-1:0]  sel;
    logic [CH_W-1:0]  pick;
    logic [CH_W-1:0]  cand;
    logic             found;
    logic             tick;
    logic             accept;
    logic [7:0]       cmd_sat;

    servo_tick_gen #(
        .STEP_TICKS(STEP_TICKS)
    ) u_tick (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .tick  (tick)
    );

    assign accept  = cmd_valid && cmd_ready;
    assign cmd_sat = (cmd_pos > POS_MAX) ? POS_MAX : cmd_pos;

    always_comb begin
        busy = '0;
        for (int i = 0; i < CH_COUNT; i++) begin
            busy[i] = (pos[i] != target[i]);
        end
    end

    // First busy channel at or after rr_ptr in circular order.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr;
        cand  = rr_ptr;
        for (int k = 0; k < CH_COUNT; k++) begin
            cand = chan_wrap(rr_ptr, k);
            if (!found && busy[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (tick && (|busy)) begin
                    state_next = SCAN;
                end
            end
            SCAN:    state_next = found ? STEP : IDLE;
            STEP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            sel     <= '0;
            done    <= '0;
            cmd_err <= 1'b0;
            for (int i = 0; i < CH_COUNT; i++) begin
                pos[i]    <= '0;
                target[i] <= '0;
            end
        end else begin
            state   <= state_next;
            done    <= '0;
            cmd_err <= accept && (cmd_chan == 2'd3);
            if (state == SCAN) begin
                sel <= pick;
            end
            if (state == STEP) begin
                rr_ptr <= chan_wrap(sel, 1);
            end
            for (int i = 0; i < CH_COUNT; i++) begin
                if (accept && (cmd_chan == CH_W'(i))) begin
                    target[i] <= cmd_sat;
                end
                // Commands are blocked during SCAN/STEP, so target is stable here.
                if ((state == STEP) && (sel == CH_W'(i))) begin
                    if (pos[i] < target[i]) begin
                        pos[i]  <= pos[i] + 8'd1;
                        done[i] <= ((pos[i] + 8'd1) == target[i]);
                    end else if (pos[i] > target[i]) begin
                        pos[i]  <= pos[i] - 8'd1;
                        done[i] <= ((pos[i] - 8'd1) == target[i]);
                    end
                end
            end
        end
    end

    assign pwm_ctrl0 = pos[0];
    assign pwm_ctrl1 = pos[1];
    assign pwm_ctrl2 = pos[2];

endmodule

// File: tb/tb_servo_ramp_sequencer.sv
// Scoreboard bench for servo_ramp_sequencer: directed commands push their
// expected step events; a negedge monitor pops and compares each observed step.
module tb_servo_ramp_sequencer;

    localparam int STEP_TICKS = 4;

    logic       clk_in    = 1'b0;
    logic       rst_in    = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_chan  = 2'd0;
    logic [7:0] cmd_pos   = 8'd0;
    logic       cmd_ready;
    logic       cmd_err;
    logic [7:0] pwm_ctrl0;
    logic [7:0] pwm_ctrl1;
    logic [7:0] pwm_ctrl2;
    logic [2:0] busy;
    logic [2:0] done;

    int checks = 0;
    int errors = 0;

    // Expected step event: {channel, new position, done bit}
    logic [10:0] exp_q[$];
    logic [7:0]  prev_pos [3];

    servo_ramp_sequencer #(
        .STEP_TICKS(STEP_TICKS),
        .CTRL_MAX  (8)
    ) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .cmd_valid(cmd_valid),
        .cmd_chan (cmd_chan),
        .cmd_pos  (cmd_pos),
        .cmd_ready(cmd_ready),
        .cmd_err  (cmd_err),
        .pwm_ctrl0(pwm_ctrl0),
        .pwm_ctrl1(pwm_ctrl1),
        .pwm_ctrl2(pwm_ctrl2),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic nextCycle();
        @(negedge clk_in);
        #1;
    endtask

    task automatic pushStep(input int ch, input int p, input bit d);
        exp_q.push_back({2'(ch), 8'(p), d});
    endtask

    task automatic applyStimulus(input logic [1:0] ch, input logic [7:0] p);
        int n;
        cmd_valid = 1'b1;
        cmd_chan  = ch;
        cmd_pos   = p;
        n = 0;
        while (!cmd_ready && n < 100) begin
            nextCycle();
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL cmd_accept_timeout: cmd_ready stayed 0, expected 1");
        end
        nextCycle();
        cmd_valid = 1'b0;
    endtask

    task automatic doReset();
        rst_in = 1'b1;
        nextCycle();
        nextCycle();
        rst_in = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while ((busy != 3'b000 || exp_q.size() != 0) && n < 300) begin
            nextCycle();
            n++;
        end
        nextCycle();
        checkOutput({name, "_busy_clear"}, 32'(busy), 32'd0);
        checkOutput({name, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic waitPos(input int ch, input logic [7:0] p, input string name);
        int n;
        logic [7:0] cur;
        n = 0;
        cur = (ch == 0) ? pwm_ctrl0 : (ch == 1) ? pwm_ctrl1 : pwm_ctrl2;
        while (cur != p && n < 300) begin
            nextCycle();
            n++;
            cur = (ch == 0) ? pwm_ctrl0 : (ch == 1) ? pwm_ctrl1 : pwm_ctrl2;
        end
        checkOutput(name, 32'(cur), 32'(p));
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_pwm0"}, 32'(pwm_ctrl0), 32'd0);
        checkOutput({name, "_pwm1"}, 32'(pwm_ctrl1), 32'd0);
        checkOutput({name, "_pwm2"}, 32'(pwm_ctrl2), 32'd0);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_done"}, 32'(done), 32'd0);
        checkOutput({name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        checkOutput({name, "_cmd_err"}, 32'(cmd_err), 32'd0);
    endtask

    // Monitor: every position change or done pulse is one step event.
    always @(negedge clk_in) begin
        logic [7:0]  cur [3];
        logic [10:0] got;
        cur[0] = pwm_ctrl0;
        cur[1] = pwm_ctrl1;
        cur[2] = pwm_ctrl2;
        for (int c = 0; c < 3; c++) begin
            if (rst_in) begin
                prev_pos[c] = cur[c];
            end else if (cur[c] != prev_pos[c] || done[c]) begin
                got = {2'(c), cur[c], done[c]};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_step: chan %0d pos %0d done %0b, expected no step", c, cur[c], done[c]);
                end else begin
                    checkOutput("step_event", 32'(got), 32'(exp_q.pop_front()));
                end
                prev_pos[c] = cur[c];
            end
        end
    end

    initial begin
        // Reset state
        #1;
        checkResetState("reset");
        doReset();
        checkResetState("post_reset");

        // Single channel ramp 0 -> 3
        pushStep(0, 1, 0);
        pushStep(0, 2, 0);
        pushStep(0, 3, 1);
        applyStimulus(2'd0, 8'd3);
        checkOutput("s1_busy_after_cmd", 32'(busy), 32'b001);
        waitDone("s1");
        checkOutput("s1_pwm1", 32'(pwm_ctrl1), 32'd0);
        checkOutput("s1_pwm2", 32'(pwm_ctrl2), 32'd0);

        // Three channels in round-robin order
        doReset();
        pushStep(0, 1, 0);
        pushStep(1, 1, 0);
        pushStep(2, 1, 0);
        pushStep(0, 2, 1);
        pushStep(1, 2, 1);
        pushStep(2, 2, 1);
        applyStimulus(2'd0, 8'd2);
        applyStimulus(2'd1, 8'd2);
        applyStimulus(2'd2, 8'd2);
        waitDone("s2");

        // Saturating command
        doReset();
        for (int p = 1; p <= 8; p++) begin
            pushStep(1, p, p == 8);
        end
        applyStimulus(2'd1, 8'd200);
        waitDone("s3");
        checkOutput("s3_pwm1_final", 32'(pwm_ctrl1), 32'd8);

        // Reversing retarget mid-ramp
        doReset();
        for (int p = 1; p <= 4; p++) begin
            pushStep(0, p, 0);
        end
        applyStimulus(2'd0, 8'd6);
        waitPos(0, 8'd4, "s4_reach4");
        pushStep(0, 3, 0);
        pushStep(0, 2, 1);
        applyStimulus(2'd0, 8'd2);
        waitDone("s4");
        checkOutput("s4_pwm0_final", 32'(pwm_ctrl0), 32'd2);

        // Illegal channel, then a command held across a slot
        doReset();
        applyStimulus(2'd3, 8'd5);
        checkOutput("s5_cmd_err_pulse", 32'(cmd_err), 32'd1);
        checkOutput("s5_busy_unchanged", 32'(busy), 32'd0);
        checkOutput("s5_pwm0_unchanged", 32'(pwm_ctrl0), 32'd0);
        nextCycle();
        checkOutput("s5_cmd_err_cleared", 32'(cmd_err), 32'd0);

        pushStep(0, 1, 0);
        pushStep(1, 1, 0);
        pushStep(0, 2, 0);
        pushStep(1, 2, 0);
        pushStep(0, 3, 1);
        pushStep(1, 3, 0);
        pushStep(1, 4, 1);
        applyStimulus(2'd0, 8'd3);
        begin
            int n;
            n = 0;
            while (cmd_ready && n < 50) begin
                nextCycle();
                n++;
            end
            checkOutput("s5_slot_started", 32'(cmd_ready), 32'd0);
            cmd_valid = 1'b1;
            cmd_chan  = 2'd1;
            cmd_pos   = 8'd4;
            n = 0;
            while (!cmd_ready && n < 50) begin
                nextCycle();
                n++;
            end
            checkOutput("s5_held_not_accepted", 32'(busy[1]), 32'd0);
            nextCycle();
            cmd_valid = 1'b0;
            checkOutput("s5_held_accepted", 32'(busy[1]), 32'd1);
        end
        waitDone("s5");

        // Asynchronous reset mid-ramp
        doReset();
        for (int p = 1; p <= 5; p++) begin
            pushStep(2, p, 0);
        end
        applyStimulus(2'd2, 8'd8);
        waitPos(2, 8'd5, "s6_reach5");
        rst_in = 1'b1;
        #1;
        checkResetState("s6_async");
        checkOutput("s6_queue_drained", 32'(exp_q.size()), 32'd0);
        nextCycle();
        nextCycle();
        rst_in = 1'b0;
        repeat (20) nextCycle();
        checkOutput("s6_idle_busy", 32'(busy), 32'd0);
        checkOutput("s6_idle_pwm2", 32'(pwm_ctrl2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_ramp_sequencer.md
# servo_ramp_sequencer

Slew-limiting command scheduler for the three-channel servo PWM controller. It accepts position commands (0..CTRL_MAX) from one requester and drives the controller's three 8-bit position inputs `pwm_ctrl0..2`. Positions move toward their targets one step at a time. A single shared step slot per tick is granted round-robin among channels still in motion, which bounds aggregate servo slew and supply current.

## Interface
Parameters:
- `STEP_TICKS`, default 5000000: clk_in cycles per step slot (100 ms at 50 MHz); legal range ≥ 4.
- `CTRL_MAX`, default 8: highest legal position code; commands above it saturate to it.

Ports:
- `clk_in`  in  1  system clock; one clock domain.
- `rst_in`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command request.
- `cmd_chan`  in  2  target channel, 0..2; 3 is illegal.
- `cmd_pos`  in  8  requested position code.
- `cmd_ready`  out  1  command can be accepted this cycle.
- `cmd_err`  out  1  one-cycle pulse: an accepted command had `cmd_chan == 3`.
- `pwm_ctrl0`, `pwm_ctrl1`, `pwm_ctrl2`  out  8 each  current position per channel, registered.
- `busy`  out  3  bit i = channel i position differs from its target.
- `done`  out  3  bit i pulses for one cycle when channel i reaches its target by stepping.

## Operation
- Handshake: a command is accepted on the rising edge where `cmd_valid && cmd_ready`. `cmd_valid` may be held; each accepting edge consumes one command.
- Accepted legal command: `target[cmd_chan] <= min(cmd_pos, CTRL_MAX)`. This overwrites any in-flight target; a retarget mid-ramp is legal. Position is never changed directly by a command.
- Accepted command with `cmd_chan == 3`: no state change; `cmd_err` is high for the following cycle.
- `busy[i] = (pos[i] != target[i])`, decoded from registers.
- `tick` comes from the free-running counter 0..STEP_TICKS-1 and is high when count == STEP_TICKS-1. The counter never stalls.
- The FSM has three states, IDLE, SCAN and STEP.
  - In IDLE, `cmd_ready` = 1.
    - If `tick` and any `busy`, go to SCAN.
    - Otherwise stay in IDLE.
  - In SCAN, `cmd_ready` = 0.
    - Search channels in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3) and latch the first busy one as `sel`.
    - Go to STEP. If none is busy (not reachable, since commands are blocked), return to IDLE.
  - In STEP, `cmd_ready` = 0.
    - Set `pos[sel] <= pos[sel] ± 1` toward the target.
    - If the new pos equals the target, pulse `done[sel]` for one cycle.
    - Set `rr_ptr <= sel+1 mod 3` and go to IDLE.
- At most one channel moves per tick.
- Arithmetic: pos and target are 8-bit unsigned and never leave 0..CTRL_MAX. There is no wrap-around.
- A retarget to the current position clears `busy` on the next cycle with no `done` pulse.
- A retarget reversing direction takes effect at the next granted step.

## Timing
- Reset values:
  - FSM = IDLE, `cmd_ready` = 1, `cmd_err` = 0.
  - pos = target = 0 on all channels, so `pwm_ctrl0..2` = 0.
  - `busy` = 0, `done` = 0, rr_ptr = 0, tick counter = 0.
- Reset asserted mid-ramp returns all of the above immediately and asynchronously; in-flight targets are lost.
- Command latency: target is updated at the accept edge N; `busy` is high in cycle N+1.
- Step latency: pos changes at the STEP edge, 2 cycles after the tick cycle. The first step after accept occurs on the first tick sampled in IDLE at or after N+1.
- `done` and the `pwm_ctrl` update are coincident: both registered on the same STEP edge.
- `cmd_ready` is low for exactly 2 cycles per granted slot and high otherwise.
- Full ramp 0→8 on one channel alone: 8 ticks. With k channels busy, each advances once every k ticks.

## Structure
- Package `servo_seq_pkg` holds:
  - `CH_COUNT` = 3
  - the FSM state enum {IDLE, SCAN, STEP}
  - the default `CTRL_MAX`
  - the channel-index width
- Sub-module `servo_tick_gen` holds the STEP_TICKS counter and tick output, with the same clk_in/rst_in.
- Arbitration and the position registers stay in the top level.

## Test plan
All scenarios use STEP_TICKS = 4.
1. Reset, then `cmd(chan 0, pos 3)`:
   - `busy` = 001.
   - `pwm_ctrl0` reads 1, 2, 3 on successive slots.
   - `done[0]` pulses with the 3 transition, then `busy` = 000.
   - `pwm_ctrl1`/`pwm_ctrl2` stay 0.
2. Commands ch0→2, ch1→2, ch2→2 issued back-to-back:
   - Steps are granted in order 0, 1, 2, 0, 1, 2.
   - Each `done` pulses once; 6 slots total.
3. `cmd(ch1, 200)`:
   - Target saturates to 8; ramp ends at `pwm_ctrl1` = 8 after 8 slots.
4. Retarget ch0 from 6 to 2 after ch0 reaches 4:
   - Next steps give 3, then 2; `done[0]` pulses once, at 2.
5. `cmd(ch3, 5)`:
   - `cmd_err` pulses one cycle; no output or `busy` change.
   - `cmd_valid` held across a SCAN/STEP window is accepted on the first edge after `cmd_ready` returns high.
6. Assert `rst_in` mid-ramp with ch2 at 5:
   - All outputs return to reset values asynchronously.
   - No step occurs until a new command.
